// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: M0 has fixed priority, M1 is forced through after STARVE_MAX losses.
// Optional access timeout is enabled by defining DBUS_TIMEOUT_EN.
module dbus_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  input  logic [2:0]  M0_LEN,
  output logic        M0_ACK,
  output logic [31:0] M0_RDATA,
  output logic        M0_ERR,
  output logic        M0_STALL,
  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  input  logic [2:0]  M1_LEN,
  output logic        M1_ACK,
  output logic [31:0] M1_RDATA,
  output logic        M1_ERR,
  output logic [31:0] DADDR,
  output logic [31:0] DATAO,
  output logic [2:0]  DLEN,
  output logic        DRD,
  output logic        DWR,
  input  logic [31:0] DATAI,
  input  logic        DRDY,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state, state_nxt;
  logic        owner;        // 0 = M0, 1 = M1
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  len_q;
  logic [3:0]  starve_cnt;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;
  logic        err_q;
  logic        start;
  logic        pick_m1;
  logic        abort;

  assign start   = (state == IDLE) && (M0_REQ || M1_REQ);
  assign pick_m1 = M1_REQ && (!M0_REQ || (starve_cnt == STARVE_LIM));

`ifdef DBUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES)                  tmo_cnt <= 8'd0;
    else if (state != ACCESS) tmo_cnt <= 8'd0;
    else                      tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign abort = (state == ACCESS) && !DRDY && (tmo_cnt == TMO_LAST);
`else
  // TIMEOUT is never 0, so this stays constant 0 while keeping the parameter referenced.
  assign abort = (TIMEOUT == 0);
`endif

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    DRD       = 1'b0;
    DWR       = 1'b0;
    M0_ACK    = 1'b0;
    M1_ACK    = 1'b0;
    BUSY      = (state != IDLE);
    case (state)
      IDLE:    if (M0_REQ || M1_REQ) state_nxt = ACCESS;
      ACCESS: begin
        DRD = !we_q;
        DWR = we_q;
        if (DRDY || abort) state_nxt = RESP;
      end
      RESP: begin
        M0_ACK    = !owner;
        M1_ACK    = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign M0_ERR   = M0_ACK && err_q;
  assign M1_ERR   = M1_ACK && err_q;
  assign M0_STALL = M0_REQ && !M0_ACK;
  assign M0_RDATA = rdata0_q;
  assign M1_RDATA = rdata1_q;
  assign DADDR    = addr_q;
  assign DATAO    = wdata_q;
  assign DLEN     = len_q;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      owner    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      len_q    <= 3'b000;
      err_q    <= 1'b0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      if (start) begin
        owner   <= pick_m1;
        we_q    <= pick_m1 ? M1_WE    : M0_WE;
        addr_q  <= pick_m1 ? M1_ADDR  : M0_ADDR;
        wdata_q <= pick_m1 ? M1_WDATA : M0_WDATA;
        len_q   <= pick_m1 ? M1_LEN   : M0_LEN;
        err_q   <= 1'b0;
      end
      if (state == ACCESS) begin
        if (DRDY) begin
          if (!we_q) begin
            if (owner) rdata1_q <= DATAI;
            else       rdata0_q <= DATAI;
          end
        end else if (abort) begin
          err_q <= 1'b1;
          if (owner) rdata1_q <= 32'h0;
          else       rdata0_q <= 32'h0;
        end
      end
    end
  end

  // Counts M0 wins while M1 is waiting; any M1 win or M1 withdrawing its request resets it.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      starve_cnt <= 4'd0;
    end else if (start && pick_m1) begin
      starve_cnt <= 4'd0;
    end else if (start && M1_REQ) begin
      if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
    end else if (!M1_REQ) begin
      starve_cnt <= 4'd0;
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dbus_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 16;

  logic        CLK = 1'b0;
  logic        RES;
  logic        M0_REQ, M0_WE, M1_REQ, M1_WE;
  logic [31:0] M0_ADDR, M0_WDATA, M1_ADDR, M1_WDATA;
  logic [2:0]  M0_LEN, M1_LEN;
  logic        M0_ACK, M0_ERR, M0_STALL, M1_ACK, M1_ERR;
  logic [31:0] M0_RDATA, M1_RDATA;
  logic [31:0] DADDR, DATAO, DATAI;
  logic [2:0]  DLEN;
  logic        DRD, DWR, DRDY, BUSY;

  int checks = 0;
  int errors = 0;

  dbus_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RES(RES),
    .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA), .M0_LEN(M0_LEN),
    .M0_ACK(M0_ACK), .M0_RDATA(M0_RDATA), .M0_ERR(M0_ERR), .M0_STALL(M0_STALL),
    .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA), .M1_LEN(M1_LEN),
    .M1_ACK(M1_ACK), .M1_RDATA(M1_RDATA), .M1_ERR(M1_ERR),
    .DADDR(DADDR), .DATAO(DATAO), .DLEN(DLEN), .DRD(DRD), .DWR(DWR),
    .DATAI(DATAI), .DRDY(DRDY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [2:0] pick_len();
    case ($urandom_range(0, 2))
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Transaction-level reference: one transfer in flight, phase 0 idle / 1 on the bus / 2 reply.
  int          ph = 0;
  int          own = 0;
  int          starve = 0;
  int          tcnt = 0;
  logic        t_we, ex_err, ack0e, ack1e;
  logic [31:0] t_addr, t_wdata;
  logic [2:0]  t_len;
  logic [31:0] ex_rd [2];

  always @(negedge CLK) begin
    if (RES) begin
      ph = 0; starve = 0; ex_err = 1'b0;
      ex_rd[0] = 32'h0; ex_rd[1] = 32'h0;
      chk("rst_busy", BUSY, 0);
      chk("rst_strobe", {DRD, DWR, M0_ACK, M1_ACK}, 0);
      chk("rst_rdata", M0_RDATA | M1_RDATA, 0);
    end else begin
      ack0e = (ph == 2) && (own == 0);
      ack1e = (ph == 2) && (own == 1);
      chk("busy", BUSY, ph != 0);
      chk("drd", DRD, (ph == 1) && !t_we);
      chk("dwr", DWR, (ph == 1) && t_we);
      chk("ack0", M0_ACK, ack0e);
      chk("ack1", M1_ACK, ack1e);
      chk("err0", M0_ERR, ack0e && ex_err);
      chk("err1", M1_ERR, ack1e && ex_err);
      chk("rdata0", M0_RDATA, ex_rd[0]);
      chk("rdata1", M1_RDATA, ex_rd[1]);
      chk("stall", M0_STALL, M0_REQ && !ack0e);
      if (ph == 1) begin
        chk("daddr", DADDR, t_addr);
        chk("datao", DATAO, t_wdata);
        chk("dlen", DLEN, t_len);
      end
      case (ph)
        0: begin
          if (M0_REQ || M1_REQ) begin
            own     = (M1_REQ && (!M0_REQ || starve == STARVE_MAX)) ? 1 : 0;
            t_we    = own ? M1_WE    : M0_WE;
            t_addr  = own ? M1_ADDR  : M0_ADDR;
            t_wdata = own ? M1_WDATA : M0_WDATA;
            t_len   = own ? M1_LEN   : M0_LEN;
            ex_err  = 1'b0;
            tcnt    = 0;
            ph      = 1;
            if (own == 1)  starve = 0;
            else if (M1_REQ) starve = (starve < 15) ? starve + 1 : 15;
          end
        end
        1: begin
          if (DRDY) begin
            if (!t_we) ex_rd[own] = DATAI;
            ph = 2;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (tcnt == TIMEOUT - 1) begin
            ex_rd[own] = 32'h0;
            ex_err     = 1'b1;
            ph         = 2;
          end
`endif
          else tcnt++;
        end
        default: ph = 0;
      endcase
      if (!M1_REQ) starve = 0;
    end
  end

  int          n, dwr_n, stall_n, got, ackn;
  logic        a0, a1, err_s;
  logic [31:0] rd_s;

  initial begin
    RES = 1'b1; DRDY = 1'b0; DATAI = 32'h0;
    M0_REQ = 1'b0; M0_WE = 1'b0; M0_ADDR = 32'h0; M0_WDATA = 32'h0; M0_LEN = 3'b100;
    M1_REQ = 1'b0; M1_WE = 1'b0; M1_ADDR = 32'h0; M1_WDATA = 32'h0; M1_LEN = 3'b100;
    @(negedge CLK);
    chk("reset_rdata0", M0_RDATA, 32'h0);
    chk("reset_outs", {M0_ACK, M1_ACK, M0_ERR, M1_ERR, DRD, DWR, BUSY}, 0);
    cyc(); RES = 1'b0;

    // 1: single-cycle M0 load
    cyc();
    M0_WE = 1'b0; M0_ADDR = 32'h100; M0_LEN = 3'b100; M0_REQ = 1'b1;
    DRDY = 1'b1; DATAI = 32'hCAFE_F00D;
    cyc(); @(negedge CLK);
    chk("t1_drd", DRD, 1);
    chk("t1_addr", DADDR, 32'h100);
    cyc(); @(negedge CLK);
    chk("t1_ack", M0_ACK, 1);
    chk("t1_rdata", M0_RDATA, 32'hCAFE_F00D);
    chk("t1_drd_resp", DRD, 0);
    cyc(); M0_REQ = 1'b0;

    // 2: M0 byte store with three wait cycles
    cyc();
    M0_WE = 1'b1; M0_ADDR = 32'h204; M0_WDATA = 32'h55; M0_LEN = 3'b001; M0_REQ = 1'b1;
    DRDY = 1'b0;
    dwr_n = 0; stall_n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(); DRDY = (i == 3);
      @(negedge CLK);
      if (DWR) begin
        dwr_n++;
        chk("t2_dlen", DLEN, 3'b001);
      end
      if (M0_ACK) begin
        chk("t2_stall_at_ack", M0_STALL, 0);
        break;
      end
      if (M0_STALL) stall_n++;
    end
    chk("t2_dwr_cycles", dwr_n, 4);
    chk("t2_stall_cycles", stall_n, 4);
    chk("t2_rdata_kept", M0_RDATA, 32'hCAFE_F00D);
    cyc(); M0_REQ = 1'b0; DRDY = 1'b0;

    // 3: both masters requesting back to back
    cyc();
    M0_WE = 1'b0; M0_ADDR = 32'h400; M0_LEN = 3'b100;
    M1_WE = 1'b0; M1_ADDR = 32'h500; M1_LEN = 3'b100;
    M0_REQ = 1'b1; M1_REQ = 1'b1; DRDY = 1'b1; DATAI = 32'h1111_1111;
    n = 0;
    for (int i = 0; i < 60 && n < 10; i++) begin
      @(negedge CLK);
      if (M0_ACK || M1_ACK) begin
        chk("t3_grant_is_m1", M1_ACK, (n % 5) == 4);
        n++;
      end
      cyc();
    end
    chk("t3_grant_count", n, 10);
    M0_REQ = 1'b0; M1_REQ = 1'b0;

    // 4: M1 alone
    cyc();
    M1_WE = 1'b0; M1_ADDR = 32'h300; M1_LEN = 3'b100; M1_REQ = 1'b1;
    DRDY = 1'b1; DATAI = 32'h0300_BEEF;
    cyc(); @(negedge CLK);
    chk("t4_daddr", DADDR, 32'h300);
    cyc(); @(negedge CLK);
    chk("t4_ack1", M1_ACK, 1);
    chk("t4_ack0", M0_ACK, 0);
    chk("t4_rdata1", M1_RDATA, 32'h0300_BEEF);
    chk("t4_rdata0_kept", M0_RDATA, 32'h1111_1111);
    cyc(); M1_REQ = 1'b0;

    // 5: memory never answers
    cyc();
    M0_WE = 1'b0; M0_ADDR = 32'h600; M0_LEN = 3'b100; M0_REQ = 1'b1; DRDY = 1'b0;
    got = 0; err_s = 1'b0; rd_s = 32'hFFFF_FFFF;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (got != 0) M0_REQ = 1'b0;
      @(negedge CLK);
      if (M0_ACK && got == 0) begin
        got = i; err_s = M0_ERR; rd_s = M0_RDATA;
      end
    end
`ifdef DBUS_TIMEOUT_EN
    chk("t5_ack_cycle", got, 17);
    chk("t5_err", err_s, 1);
    chk("t5_rdata", rd_s, 32'h0);
`else
    chk("t5_no_ack", got, 0);
    chk("t5_busy", BUSY, 1);
    cyc(); DRDY = 1'b1;
    cyc(); @(negedge CLK);
    chk("t5_late_ack", M0_ACK, 1);
    cyc(); M0_REQ = 1'b0;
`endif

    // 6: reset in the middle of an access
    cyc();
    M0_WE = 1'b0; M0_ADDR = 32'h700; M0_LEN = 3'b100; M0_REQ = 1'b1; DRDY = 1'b0;
    cyc(); @(negedge CLK);
    chk("t6_drd_before", DRD, 1);
    @(posedge CLK); #2;
    RES = 1'b1;
    #1;
    chk("t6_drd_dropped", DRD | DWR, 0);
    chk("t6_busy_dropped", BUSY, 0);
    M0_REQ = 1'b0;
    @(negedge CLK);
    cyc(); RES = 1'b0;
    ackn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (M0_ACK) ackn++;
      cyc();
    end
    chk("t6_no_ack", ackn, 0);
    M0_ADDR = 32'h704; M0_REQ = 1'b1; DRDY = 1'b1; DATAI = 32'h7777_0704;
    cyc(); cyc(); @(negedge CLK);
    chk("t6_ack_after", M0_ACK, 1);
    chk("t6_rdata_after", M0_RDATA, 32'h7777_0704);
    cyc(); M0_REQ = 1'b0;

    // Random traffic from both masters with a random-latency memory
    a0 = 1'b0; a1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (a0) M0_REQ = 1'b0;
      else if (!M0_REQ && $urandom_range(0, 2) == 0) begin
        M0_WE = 1'($urandom_range(0, 1)); M0_ADDR = $urandom; M0_WDATA = $urandom;
        M0_LEN = pick_len(); M0_REQ = 1'b1;
      end
      if (a1) M1_REQ = 1'b0;
      else if (!M1_REQ && $urandom_range(0, 1) == 0) begin
        M1_WE = 1'($urandom_range(0, 1)); M1_ADDR = $urandom; M1_WDATA = $urandom;
        M1_LEN = pick_len(); M1_REQ = 1'b1;
      end
      DRDY  = ($urandom_range(0, 3) != 0);
      DATAI = $urandom;
      @(negedge CLK);
      a0 = M0_ACK; a1 = M1_ACK;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
